// File: rtl/det_pkg.sv
// det_pkg: shared defaults, one-hot FSM encoding and matrix helpers for the
// determinant-engine feeder (det_matrix_feeder and det_mat_regfile).
package det_pkg;

  localparam int N_DEF    = 8;
  localparam int DW_DEF   = 8;
  localparam int DETW_DEF = 32;

  // Widest matrix bus the identity helper can describe (12-bit bit index).
  localparam int MAT_MAXW = 4096;

  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_FILL   = 6'b000010,
    S_START  = 6'b000100,
    S_WAIT   = 6'b001000,
    S_ACK    = 6'b010000,
    S_RESULT = 6'b100000
  } det_state_e;

  function automatic int elem_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

  // Identity image for an n x n matrix of dw-bit elements; callers keep the
  // low n*n*dw bits. A diagonal value of 1 is just bit 0 of the element.
  function automatic logic [MAT_MAXW-1:0] identity_mat(input int n, input int dw);
    logic [MAT_MAXW-1:0] m;
    logic [11:0]         bi;
    m = '0;
    for (int r = 0; r < n; r++) begin
      bi    = 12'(elem_idx(r, r, n) * dw);
      m[bi] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/det_mat_regfile.sv
// det_mat_regfile: N x N element register array with a clear-to-identity
// strobe, a single row/col write port and a flat row-major output bus.
module det_mat_regfile
  import det_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clr,
  input  logic              we,
  input  logic [3:0]        row,
  input  logic [3:0]        col,
  input  logic [DW-1:0]     wdata,
  output logic [N*N*DW-1:0] mat
);

  localparam int                  IW      = $clog2(N * N * DW);
  localparam logic [MAT_MAXW-1:0] ID_FULL = identity_mat(N, DW);
  localparam logic [N*N*DW-1:0]   ID_MAT  = ID_FULL[N*N*DW-1:0];

  logic [IW-1:0] wbase;

  assign wbase = IW'(elem_idx(int'(row), int'(col), N) * DW);

  // clr has priority so a new load always starts from clean identity padding.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mat <= ID_MAT;
    end else if (clr) begin
      mat <= ID_MAT;
    end else if (we) begin
      mat[wbase +: DW] <= wdata;
    end
  end

endmodule

// File: rtl/det_matrix_feeder.sv
// det_matrix_feeder: loads an identity-padded N x N matrix from an element
// stream, runs the Start/Done/Ack handshake with the determinant engine and
// offers the result on a valid/ready port. Optional WAIT timeout: DETF_TIMEOUT_EN.
module det_matrix_feeder
  import det_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int DW   = DW_DEF,
  parameter int DETW = DETW_DEF
`ifdef DETF_TIMEOUT_EN
  , parameter int TMO = 4096
`endif
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cmd_go,
  input  logic [3:0]        cmd_dim,
  output logic              cmd_err,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  output logic              in_ready,
  output logic [N*N*DW-1:0] mat,
  output logic              eng_start,
  output logic              eng_ack,
  input  logic              eng_done,
  input  logic [DETW-1:0]   eng_det,
  output logic              res_valid,
  output logic [DETW-1:0]   res_det,
  input  logic              res_ready,
  output logic              busy,
  output det_state_e        dbg_state
`ifdef DETF_TIMEOUT_EN
  , output logic            tmo_err
`endif
);

  // Handshakes: an element moves on in_valid & in_ready; the result moves on
  // res_valid & res_ready. in_ready and res_valid do not depend on in_valid
  // or res_ready in the same cycle.

  localparam logic [3:0] N4 = 4'(N);

  det_state_e state, state_nxt;
  logic [3:0] dim, row, col;
  logic       dim_ok, clr, accept, last_elem;
  logic       tmo_hit, tmo_flag;

  assign dim_ok    = (cmd_dim != 4'd0) && (cmd_dim <= N4);
  assign clr       = (state == S_IDLE) && cmd_go && dim_ok;
  assign accept    = (state == S_FILL) && in_valid;
  assign last_elem = (row == dim - 4'd1) && (col == dim - 4'd1);
  assign dbg_state = state;

`ifdef DETF_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state == S_WAIT) && !eng_done && (tmo_cnt == TW'(TMO - 1));
  assign tmo_err = (state == S_ACK) && tmo_flag;

  // tmo_flag remembers why WAIT was left, so ACK knows to skip RESULT.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      if (state == S_START) tmo_cnt <= '0;
      else if (state == S_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
      if (state == S_WAIT) tmo_flag <= tmo_hit;
    end
  end
`else
  assign tmo_hit  = 1'b0;
  assign tmo_flag = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    eng_start = 1'b0;
    eng_ack   = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (clr) state_nxt = S_FILL;
      end
      S_FILL: begin
        in_ready = 1'b1;
        if (accept && last_elem) state_nxt = S_START;
      end
      S_START: begin
        eng_start = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done || tmo_hit) state_nxt = S_ACK;
      end
      S_ACK: begin
        eng_ack   = 1'b1;
        state_nxt = tmo_flag ? S_IDLE : S_RESULT;
      end
      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= S_IDLE;
      dim     <= 4'd0;
      row     <= 4'd0;
      col     <= 4'd0;
      cmd_err <= 1'b0;
      res_det <= '0;
    end else begin
      state   <= state_nxt;
      cmd_err <= (state == S_IDLE) && cmd_go && !dim_ok;
      if (clr) begin
        dim <= cmd_dim;
        row <= 4'd0;
        col <= 4'd0;
      end else if (accept) begin
        if (col == dim - 4'd1) begin
          col <= 4'd0;
          row <= row + 4'd1;
        end else begin
          col <= col + 4'd1;
        end
      end
      if ((state == S_WAIT) && eng_done) res_det <= eng_det;
      else if (tmo_hit) res_det <= '0;
    end
  end

  det_mat_regfile #(.N(N), .DW(DW)) u_regfile (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (clr),
    .we    (accept),
    .row   (row),
    .col   (col),
    .wdata (in_data),
    .mat   (mat)
  );

endmodule

// File: tb/tb_det_matrix_feeder.sv
// tb_det_matrix_feeder: directed and randomized loads against an array model
// of the padded matrix plus an engine BFM and an expected-result queue.
module tb_det_matrix_feeder;

  localparam int N    = 8;
  localparam int DW   = 8;
  localparam int DETW = 32;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              cmd_go = 1'b0;
  logic [3:0]        cmd_dim = 4'd0;
  logic              cmd_err;
  logic              in_valid = 1'b0;
  logic [DW-1:0]     in_data = '0;
  logic              in_ready;
  logic [N*N*DW-1:0] mat;
  logic              eng_start;
  logic              eng_ack;
  logic              eng_done = 1'b0;
  logic [DETW-1:0]   eng_det = '0;
  logic              res_valid;
  logic [DETW-1:0]   res_det;
  logic              res_ready = 1'b0;
  logic              busy;
  logic [5:0]        dbg_state;
`ifdef DETF_TIMEOUT_EN
  logic              tmo_err;
`endif

  det_matrix_feeder #(
    .N(N), .DW(DW), .DETW(DETW)
`ifdef DETF_TIMEOUT_EN
    , .TMO(16)
`endif
  ) dut (
    .Clk(Clk), .Reset(Reset), .cmd_go(cmd_go), .cmd_dim(cmd_dim), .cmd_err(cmd_err),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .mat(mat),
    .eng_start(eng_start), .eng_ack(eng_ack), .eng_done(eng_done), .eng_det(eng_det),
    .res_valid(res_valid), .res_det(res_det), .res_ready(res_ready), .busy(busy),
    .dbg_state(dbg_state)
`ifdef DETF_TIMEOUT_EN
    , .tmo_err(tmo_err)
`endif
  );

  always #5 Clk = ~Clk;

  int              checks = 0;
  int              failures = 0;
  logic [DETW-1:0] exp_q[$];
  int              exp_mat[N][N];
  int              data_q[$];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_identity();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        exp_mat[r][c] = (r == c) ? 1 : 0;
  endtask

  task automatic check_mat(input string tag);
    logic [N*N*DW-1:0] e;
    e = '0;
    for (int i = N * N - 1; i >= 0; i--)
      e = {e[N*N*DW-DW-1:0], DW'(exp_mat[i / N][i % N])};
    checks++;
    assert (mat === e) else begin
      failures++;
      $error("FAIL %s obs=0x%0h exp=0x%0h", tag, mat, e);
    end
  endtask

  task automatic reset_check(input string tag);
    Reset = 1'b0;
    cmd_go = 1'b0; in_valid = 1'b0; eng_done = 1'b0; res_ready = 1'b0;
    #1;
    model_identity();
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_start"}, eng_start, 0);
    check({tag, "_ack"}, eng_ack, 0);
    check({tag, "_valid"}, res_valid, 0);
    check({tag, "_det"}, res_det, 0);
    check({tag, "_err"}, cmd_err, 0);
    check_mat({tag, "_mat"});
    #2;
    Reset = 1'b1;
  endtask

  // gap: 0 back-to-back, 1 one idle cycle before each element, 2 random idles
  task automatic do_load(input int d, input int gap);
    int g;
    cmd_go = 1'b1; cmd_dim = 4'(d);
    tick();
    cmd_go = 1'b0;
    check("fill_busy", busy, 1);
    check("fill_ready", in_ready, 1);
    model_identity();
    for (int i = 0; i < d * d; i++) begin
      g = (gap == 1) ? 1 : ((gap == 2) ? int'($urandom_range(0, 2)) : 0);
      in_valid = 1'b0;
      in_data  = DW'($urandom);
      repeat (g) tick();
      in_valid = 1'b1;
      in_data  = DW'(data_q[i]);
      exp_mat[i / d][i % d] = data_q[i];
      tick();
    end
    in_valid = 1'b0;
    check("start_pulse", eng_start, 1);
    check("ready_drop", in_ready, 0);
    check("onehot_start", 64'($onehot(dbg_state)), 1);
    check_mat("mat_start");
  endtask

  task automatic engine(input int delay, input logic [DETW-1:0] det);
    exp_q.push_back(det);
    tick();
    check("start_one_cycle", eng_start, 0);
    check("wait_busy", busy, 1);
    repeat (delay) begin
      tick();
      check("wait_no_ack", eng_ack, 0);
    end
    eng_done = 1'b1; eng_det = det;
    tick();
    check("ack_pulse", eng_ack, 1);
    check("ack_det", res_det, det);
    eng_done = 1'b0; eng_det = $urandom;
    tick();
    check("ack_one_cycle", eng_ack, 0);
    check("res_valid", res_valid, 1);
    check_mat("mat_result");
  endtask

  task automatic drain(input int hold);
    logic [DETW-1:0] exp;
    exp = exp_q.pop_front();
    repeat (hold) begin
      check("hold_valid", res_valid, 1);
      tick();
    end
    check("res_det", res_det, exp);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("idle_valid", res_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    int d, delay;
    logic [DETW-1:0] det;

    tick();
    reset_check("rst0");
    tick();

    // Illegal dimensions; stray in_valid in IDLE must not write mat.
    foreach (data_q[i]) data_q.delete();
    for (int k = 0; k < 3; k++) begin
      cmd_go = 1'b1; cmd_dim = (k == 0) ? 4'd0 : ((k == 1) ? 4'd9 : 4'd15);
      in_valid = 1'b1; in_data = 8'h5A;
      tick();
      cmd_go = 1'b0; in_valid = 1'b0;
      check("err_pulse", cmd_err, 1);
      check("err_busy", busy, 0);
      tick();
      check("err_one_cycle", cmd_err, 0);
      check_mat("err_mat");
    end

    // dim=3 reference load.
    data_q = '{6, 1, 1, 4, -2, 5, 2, 8, 7};
    do_load(3, 0);
    engine(5, 32'hFFFF_FECE);
    check("det_m306", res_det, 32'hFFFF_FECE);
    drain(1);
    check_mat("mat_after_idle");

    // dim=2 with gaps.
    data_q = '{3, 1, 2, 4};
    do_load(2, 1);
    engine(2, 32'd10);
    drain(0);

    // Reset mid-FILL after 4 of 9 elements.
    cmd_go = 1'b1; cmd_dim = 4'd3;
    tick();
    cmd_go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = DW'(i + 20);
      tick();
    end
    in_valid = 1'b0;
    check("mid_fill_ready", in_ready, 1);
    reset_check("rst_fill");
    tick();

    // Reset while waiting on the engine.
    data_q = '{1, 2, 3, 4};
    do_load(2, 0);
    repeat (3) tick();
    check("wait_state_busy", busy, 1);
    reset_check("rst_wait");
    tick();

    // dim=1 after reset.
    data_q = '{5};
    do_load(1, 0);
    engine(3, 32'd5);
    drain(0);

    // Result held for 20 cycles; cmd_go in RESULT is ignored.
    data_q = '{-7, 3, 9, 2};
    do_load(2, 2);
    det = $urandom;
    engine(1, det);
    for (int i = 0; i < 20; i++) begin
      cmd_go = (i == 10); cmd_dim = 4'd2;
      tick();
      check("hold_valid20", res_valid, 1);
      check("hold_det20", res_det, det);
      check("hold_no_err", cmd_err, 0);
    end
    cmd_go = 1'b0;
    check("hold_busy", busy, 1);
    drain(0);

    // Randomized loads.
    for (int it = 0; it < 6; it++) begin
      d = $urandom_range(1, N);
      data_q.delete();
      for (int i = 0; i < d * d; i++) data_q.push_back(int'($urandom_range(0, 255)) - 128);
      det   = $urandom;
      delay = $urandom_range(0, 6);
      do_load(d, 2);
      engine(delay, det);
      drain($urandom_range(0, 3));
    end

    // Engine never raises Done.
    data_q = '{7};
    do_load(1, 0);
    tick();
`ifdef DETF_TIMEOUT_EN
    repeat (15) begin
      check("tmo_quiet", tmo_err, 0);
      tick();
    end
    tick();
    check("tmo_err", tmo_err, 1);
    check("tmo_ack", eng_ack, 1);
    check("tmo_det", res_det, 0);
    tick();
    check("tmo_idle", busy, 0);
    check("tmo_no_result", res_valid, 0);
    check("tmo_err_drop", tmo_err, 0);
`else
    repeat (40) tick();
    check("nodone_busy", busy, 1);
    check("nodone_ack", eng_ack, 0);
    reset_check("rst_nodone");
`endif

    check("queue_empty", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/det_matrix_feeder.md
Name: det_matrix_feeder

Overview:
- Initiator side of the determinant engine's Start/Ack handshake.
- Accepts a matrix dimension plus a row-major stream of signed entries from the input path (switch/UART front end), and assembles an N×N matrix padded to identity.
- Pulses Start to the engine, waits for its Done, captures the determinant and returns Ack.
- Presents the result on a valid/ready port to the display/output logic.

Parameters:
- N, 8, maximum matrix dimension; the matrix bus is always N×N.
- DW, 8, signed element width (two's complement).
- DETW, 32, determinant width returned by the engine.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- cmd_go  in  1  one-cycle request to begin a new matrix load.
- cmd_dim  in  4  active dimension; legal range 1..N; sampled with cmd_go.
- cmd_err  out  1  registered; pulses for one cycle on an illegal cmd_dim.
- in_valid  in  1  element available.
- in_data  in  DW  signed element, row-major order.
- in_ready  out  1  high only in FILL.
- mat  out  N*N*DW  assembled matrix; element (r,c) at bits [(r*N+c)*DW +: DW].
- eng_start  out  1  Start to the engine.
- eng_ack  out  1  Ack to the engine.
- eng_done  in  1  engine Done level.
- eng_det  in  DETW  engine determinant; valid while eng_done=1.
- res_valid  out  1  result held.
- res_det  out  DETW  captured determinant.
- res_ready  in  1  consumer accepts the result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (Reset=0, asynchronous) forces the following, regardless of current state:
  - state = IDLE;
  - mat = identity (diagonal 1, all others 0);
  - all outputs = 0, res_det = 0;
  - row/col counters = 0.
- States: IDLE, FILL, START, WAIT, ACK, RESULT. Encoding is one-hot.
- IDLE:
  - cmd_go with 1≤cmd_dim≤N → latch dim, reset mat to identity, row=col=0, go to FILL.
  - cmd_go with cmd_dim=0 or cmd_dim>N → cmd_err=1 for one cycle, stay in IDLE.
- FILL:
  - in_ready=1.
  - Each in_valid&in_ready cycle writes in_data to mat(row,col).
  - col increments; when col=dim-1 it wraps to 0 and row increments.
  - Entries outside dim×dim keep their identity padding.
  - Accepting element (dim-1,dim-1) → START on the next cycle. in_ready drops in that same next cycle.
- START: eng_start=1 for exactly one cycle, then go to WAIT.
- WAIT: hold until eng_done=1.
- ACK:
  - Entered on the cycle after eng_done is seen.
  - res_det ← eng_det, captured on the WAIT→ACK edge.
  - eng_ack=1 for exactly one cycle, then go to RESULT.
- RESULT:
  - res_valid=1; res_det is held stable.
  - res_ready=1 → IDLE next cycle; res_valid drops.
- mat is stable from START through RESULT; it changes only in FILL or on cmd_go acceptance.
- cmd_go outside IDLE is ignored; no cmd_err is raised.
- in_valid outside FILL is ignored, since in_ready=0.
- Latency: eng_start rises 1 cycle after the last element is accepted. eng_ack rises 1 cycle after eng_done is first seen high.
- dim=1: one element is accepted and mat(0,0) is written.
- res_det is passed through unmodified; there is no sign extension.

Optional Feature:
- Macro: DETF_TIMEOUT_EN.
- Defined:
  - parameter TMO (default 4096) and output tmo_err are added.
  - A WAIT-state cycle counter runs; reaching TMO cycles without eng_done → tmo_err=1 for one cycle, eng_ack pulsed once, res_det=0, and state goes to IDLE (RESULT is skipped).
  - The counter clears on entering WAIT.
- Undefined: no counter and no tmo_err port; WAIT holds indefinitely.

Decomposition:
- Shared package det_pkg holds:
  - N, DW, DETW defaults;
  - the state enum/localparams;
  - an identity-matrix constant function;
  - the element index helper (r*N+c).
- Sub-module det_mat_regfile holds the N×N register array, with a clear-to-identity strobe, row/col write port and flat mat output.
- FSM, counters and handshakes stay in det_matrix_feeder.

Test Plan:
- Load, dim=3 + 9 entries {6,1,1,4,-2,5,2,8,7}, engine BFM returns -306 after 5 cycles:
  - mat is the 3×3 block padded with identity;
  - eng_start is high for exactly 1 cycle;
  - eng_ack is high for 1 cycle;
  - res_det=-306 (0xFFFFFECE);
  - IDLE after res_ready.
- in_valid gaps (every other cycle) with dim=2 {3,1,2,4}, BFM det=10 → res_det=10; no element is skipped or duplicated.
- Illegal dims: cmd_dim=0 and cmd_dim=9 → cmd_err pulses, busy stays 0, mat stays identity.
- Reset asserted mid-FILL (after 4 of 9 elements) and again in WAIT → immediate IDLE, identity mat, eng_start/eng_ack/res_valid=0. A fresh dim=1 {5}, BFM det=5 → res_det=5.
- res_ready held low for 20 cycles → res_valid and res_det stay stable. cmd_go issued during RESULT is ignored.
- With DETF_TIMEOUT_EN, TMO=16, BFM never raises Done → tmo_err at WAIT cycle 16, eng_ack pulse, IDLE. Without the macro, busy stays 1.
